// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of a small single-port RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority (default: round-robin).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  done_a,
  output logic                  done_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  last_a
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cap_we, cap_we_n;
  logic [ADDR_WIDTH-1:0] cap_addr, cap_addr_n;
  logic [DATA_WIDTH-1:0] cap_wdata, cap_wdata_n;

  logic                  gnt_a_n, gnt_b_n;
  logic                  done_a_n, done_b_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                  busy_n, last_a_n;
  logic                  win_a;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign win_a = req_a;
`else
  // On a tie the previous winner yields.
  assign win_a = req_a & (~req_b | ~last_a);
`endif

  always_comb begin
    state_n     = state;
    cap_we_n    = cap_we;
    cap_addr_n  = cap_addr;
    cap_wdata_n = cap_wdata;
    gnt_a_n     = gnt_a;
    gnt_b_n     = gnt_b;
    done_a_n    = 1'b0;
    done_b_n    = 1'b0;
    rdata_n     = rdata;
    last_a_n    = last_a;
    unique case (state)
      IDLE: begin
        if (req_a | req_b) begin
          state_n     = ACCESS;
          last_a_n    = win_a;
          gnt_a_n     = win_a;
          gnt_b_n     = ~win_a;
          cap_we_n    = win_a ? we_a : we_b;
          cap_addr_n  = win_a ? addr_a : addr_b;
          cap_wdata_n = win_a ? wdata_a : wdata_b;
        end
      end
      ACCESS: begin
        state_n  = DONE;
        done_a_n = last_a;
        done_b_n = ~last_a;
        if (!cap_we) rdata_n = mem[cap_addr];
      end
      DONE: begin
        state_n = IDLE;
        gnt_a_n = 1'b0;
        gnt_b_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        gnt_a_n = 1'b0;
        gnt_b_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      last_a    <= 1'b0;
    end else begin
      state     <= state_n;
      cap_we    <= cap_we_n;
      cap_addr  <= cap_addr_n;
      cap_wdata <= cap_wdata_n;
      gnt_a     <= gnt_a_n;
      gnt_b     <= gnt_b_n;
      done_a    <= done_a_n;
      done_b    <= done_b_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      last_a    <= last_a_n;
    end
  end

  // Contents survive reset; an async reset before ACCESS leaves state IDLE.
  always_ff @(posedge clk_2) begin
    if (state == ACCESS && cap_we) mem[cap_addr] <= cap_wdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter against a transaction-level model.
// Directed test-plan steps followed by random traffic.
module tb_ram_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       req_a, req_b, we_a, we_b;
  logic [1:0] addr_a, addr_b, wdata_a, wdata_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [1:0] rdata;
  logic       busy, last_a;

  ram_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(2)) dut (
    .clk_2(clk_2), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .busy(busy), .last_a(last_a)
  );

  always #5 clk_2 = ~clk_2;

  int total = 0;
  int bad = 0;

  // model: a transaction starts at edge t_start; edge t_start+1 does the
  // access; the requester owns the RAM for the two periods that follow.
  int         cyc = 0;
  int         t_start = -100;
  logic [1:0] m_mem [4];
  logic       m_last_a = 1'b0;
  logic [1:0] m_rdata = 2'd0;
  logic       c_we;
  logic [1:0] c_addr, c_wd;
  int         n_gnt_a = 0, n_gnt_b = 0;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  age;
    logic act;
    age = cyc - t_start;
    act = (age < 2);
    chk("gnt_a", 8'(gnt_a), 8'(act & m_last_a));
    chk("gnt_b", 8'(gnt_b), 8'(act & ~m_last_a));
    chk("done_a", 8'(done_a), 8'((age == 1) & m_last_a));
    chk("done_b", 8'(done_b), 8'((age == 1) & ~m_last_a));
    chk("busy", 8'(busy), 8'(act));
    chk("last_a", 8'(last_a), 8'(m_last_a));
    chk("rdata", 8'(rdata), 8'(m_rdata));
    chk("excl", 8'(gnt_a & gnt_b), 8'd0);
  endtask

  task automatic step();
    logic wa;
    @(posedge clk_2);
    cyc++;
    if (cyc - t_start == 1) begin
      if (c_we) m_mem[c_addr] = c_wd;
      else m_rdata = m_mem[c_addr];
    end
    if (cyc - t_start >= 3 && (req_a || req_b)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      wa = req_a;
`else
      wa = req_a && (!req_b || !m_last_a);
`endif
      m_last_a = wa;
      c_we   = wa ? we_a : we_b;
      c_addr = wa ? addr_a : addr_b;
      c_wd   = wa ? wdata_a : wdata_b;
      t_start = cyc;
      if (wa) n_gnt_a++;
      else n_gnt_b++;
    end
    @(negedge clk_2);
    check_all();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_a(logic r, logic w, logic [1:0] a, logic [1:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(logic r, logic w, logic [1:0] a, logic [1:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  initial begin
    int ga0, gb0;
    reset_n = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) @(negedge clk_2);
    check_all();
    reset_n = 1'b1;

    // A writes mem[2]=3
    set_a(1, 1, 2, 3);
    step();
    set_a(0, 0, 0, 0);
    steps(3);

    // B reads mem[2]
    set_b(1, 0, 2, 0);
    step();
    set_b(0, 0, 0, 0);
    steps(3);
    chk("rd_b_2", 8'(m_rdata), 8'd3);

    // fill the remaining words so random reads are defined
    for (int k = 0; k < 4; k++) begin
      set_a(1, 1, 2'(k), 2'(k ^ 1));
      step();
      set_a(0, 0, 0, 0);
      steps(2);
    end

    // both continuous: A writes addr1=1, B reads addr1
    ga0 = n_gnt_a;
    gb0 = n_gnt_b;
    set_a(1, 1, 1, 1);
    set_b(1, 0, 1, 0);
    steps(12);
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("fixed_b_none", 8'(n_gnt_b - gb0), 8'd0);
    set_a(0, 0, 0, 0);
    steps(6);
    chk("fixed_b_served", 8'(n_gnt_b - gb0 > 0), 8'd1);
`else
    chk("rr_a_cnt", 8'(n_gnt_a - ga0), 8'd2);
    chk("rr_b_cnt", 8'(n_gnt_b - gb0), 8'd2);
`endif
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    steps(3);

    // reset during ACCESS of a write over mem[0]=1
    set_a(1, 1, 0, 1);
    step();
    set_a(0, 0, 0, 0);
    steps(2);
    set_a(1, 1, 0, 2);
    step();
    set_a(0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    t_start = cyc - 100;
    m_last_a = 1'b0;
    m_rdata = 2'd0;
    check_all();
    @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
    set_b(1, 0, 0, 0);
    step();
    set_b(0, 0, 0, 0);
    steps(2);
    chk("rst_keep0", 8'(rdata), 8'd1);

    // inputs changed after capture do not disturb the transaction
    set_a(1, 1, 3, 2);
    step();
    set_a(0, 1, 0, 3);
    steps(2);
    set_a(1, 0, 3, 0);
    step();
    set_a(0, 0, 0, 0);
    steps(2);
    chk("cap_rd3", 8'(rdata), 8'd2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_a(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      set_b(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
